// File: rtl/seq_detect_mealy.sv
// Programmable Mealy sequence detector: scans a serial stream for an LEN-bit
// pattern with start/stop control, overlap selection, saturating count and limit.
module seq_detect_mealy #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN-1:0]   cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             in_valid,
  input  logic             in,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  localparam int unsigned FW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LEN-2:0]   hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [LEN-1:0]   pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] lim_q, lim_d;

  logic [LEN-1:0]   window;
  logic [CNT_W-1:0] count_inc;
  logic             hit;
  logic             arm;

  always_comb begin
    window    = {hist_q, in};
    hit       = (state_q == S_RUN) && in_valid && !stop &&
                (fill_q == FILL_MAX) && (window == pat_q);
    count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
    // In DONE a simultaneous stop overrides start; in IDLE stop is meaningless.
    arm       = start && ((state_q == S_IDLE) || ((state_q == S_DONE) && !stop));

    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    count_d = count_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    lim_d   = lim_q;

    if (arm) begin
      pat_d   = cfg_pattern;
      ovl_d   = cfg_overlap;
      lim_d   = cfg_limit;
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (in_valid) begin
            hist_d = window[LEN-2:0];
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
            if (hit) begin
              count_d = count_inc;
              if (!ovl_q) fill_d = '0;
              if ((lim_q != '0) && (count_inc == lim_q)) state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (stop) state_d = S_IDLE;
        end
        S_IDLE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      lim_q   <= lim_d;
    end
  end

  assign match       = hit;
  assign match_count = count_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Directed bench for seq_detect_mealy: a LEN=4/CNT_W=8 instance and a
// LEN=2/CNT_W=2 instance for counter saturation.
module tb_seq_detect_mealy;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic [7:0] cfg_limit;
  logic       in_valid, in_bit;
  logic       match, busy, done;
  logic [7:0] match_count;

  logic       start2, stop2;
  logic [1:0] cfg_pattern2;
  logic       cfg_overlap2;
  logic [1:0] cfg_limit2;
  logic       in_valid2, in_bit2;
  logic       match2, busy2, done2;
  logic [1:0] match_count2;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  seq_detect_mealy #(.LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
    .in_valid(in_valid), .in(in_bit),
    .match(match), .match_count(match_count), .busy(busy), .done(done)
  );

  seq_detect_mealy #(.LEN(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2),
    .cfg_pattern(cfg_pattern2), .cfg_overlap(cfg_overlap2), .cfg_limit(cfg_limit2),
    .in_valid(in_valid2), .in(in_bit2),
    .match(match2), .match_count(match_count2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle on dut: inputs change at negedge, match sampled 1ns later.
  task automatic drive(input logic v, input logic b, input logic stp, input logic exp_m,
                       input string tag);
    @(negedge clk);
    in_valid = v; in_bit = b; stop = stp; start = 1'b0;
    #1 chk(tag, match, exp_m);
  endtask

  task automatic arm(input logic [3:0] pat, input logic ovl, input logic [7:0] lim,
                     input logic v, input logic b);
    @(negedge clk);
    cfg_pattern = pat; cfg_overlap = ovl; cfg_limit = lim;
    start = 1'b1; stop = 1'b0; in_valid = v; in_bit = b;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idle_cycle(input logic stp);
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0; stop = stp;
  endtask

  logic [6:0] s1;
  logic [6:0] m_ovl;
  logic [6:0] m_non;
  logic [5:0] s5;

  initial begin
    rst = 1'b1; start = 0; stop = 0; cfg_pattern = '0; cfg_overlap = 0; cfg_limit = '0;
    in_valid = 0; in_bit = 0;
    start2 = 0; stop2 = 0; cfg_pattern2 = '0; cfg_overlap2 = 0; cfg_limit2 = '0;
    in_valid2 = 0; in_bit2 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", match_count, 0);
    chk("rst_match", match, 0);

    // stream 1,0,1,1,0,1,1 listed oldest first (bit 6 = first)
    s1    = 7'b1011011;
    m_ovl = 7'b0001001;
    m_non = 7'b0001000;

    arm(4'b1011, 1'b1, 8'd0, 1'b0, 1'b0);
    chk("t1_busy", busy, 1);
    chk("t1_count0", match_count, 0);
    for (int i = 6; i >= 0; i--) drive(1'b1, s1[i], 1'b0, m_ovl[i], "t1_match");
    idle_cycle(1'b0);
    chk("t1_count", match_count, 2);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    chk("t1_stop_busy", busy, 0);
    chk("t1_idle_hold", match_count, 2);

    arm(4'b1011, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("t2_count0", match_count, 0);
    for (int i = 6; i >= 0; i--) drive(1'b1, s1[i], 1'b0, m_non[i], "t2_match");
    idle_cycle(1'b0);
    chk("t2_count", match_count, 1);
    idle_cycle(1'b1);

    // limit 3 on an all-ones stream
    arm(4'b1111, 1'b1, 8'd3, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) drive(1'b1, 1'b1, 1'b0, (i >= 4), "t3_match");
    idle_cycle(1'b0);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_count", match_count, 3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, "t3_bit7");
    idle_cycle(1'b0);
    chk("t3_count_hold", match_count, 3);
    // start and stop together in DONE: stop wins
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    idle_cycle(1'b0);
    chk("t3_ss_done", done, 0);
    chk("t3_ss_busy", busy, 0);
    chk("t3_ss_count", match_count, 3);

    // gaps with in toggling
    arm(4'b1011, 1'b1, 8'd0, 1'b0, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      drive(1'b1, s1[i], 1'b0, m_ovl[i], "t4_match");
      drive(1'b0, ~s1[i], 1'b0, 1'b0, "t4_gap");
      drive(1'b0, s1[i], 1'b0, 1'b0, "t4_gap");
    end
    idle_cycle(1'b0);
    chk("t4_count", match_count, 2);

    // continue: 1,0,1 then completing 1 with stop -> suppressed
    drive(1'b1, 1'b1, 1'b0, 1'b0, "t5_pre");
    drive(1'b1, 1'b0, 1'b0, 1'b0, "t5_pre");
    drive(1'b1, 1'b1, 1'b0, 1'b0, "t5_pre");
    drive(1'b1, 1'b1, 1'b1, 1'b0, "t5_stop_match");
    idle_cycle(1'b0);
    chk("t5_busy", busy, 0);
    chk("t5_count", match_count, 2);

    // re-arm with 0110; a bit offered in the start cycle is not scanned
    s5 = 6'b110110;
    arm(4'b0110, 1'b1, 8'd0, 1'b1, 1'b0);
    for (int i = 5; i >= 0; i--) drive(1'b1, s5[i], 1'b0, (i == 0), "t5_match");
    idle_cycle(1'b0);
    chk("t5_count2", match_count, 1);

    // LEN=2 / CNT_W=2 saturation
    @(negedge clk);
    cfg_pattern2 = 2'b11; cfg_overlap2 = 1'b1; cfg_limit2 = 2'd0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] ec;
      ec = (i < 2) ? 2'd0 : ((i - 1 > 3) ? 2'd3 : 2'(i - 1));
      if (i > 0) chk("t6_count", match_count2, ec);
      in_valid2 = 1'b1; in_bit2 = 1'b1;
      #1 chk("t6_match", match2, (i >= 1));
      @(negedge clk);
    end
    chk("t6_count_sat", match_count2, 3);
    chk("t6_busy", busy2, 1);

    // reset mid-stream on both instances
    in_valid = 1'b1; in_bit = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t7_match2", match2, 0);
    chk("t7_count2", match_count2, 0);
    chk("t7_busy2", busy2, 0);
    chk("t7_done2", done2, 0);
    chk("t7_count", match_count, 0);
    chk("t7_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_mealy.md
# seq_detect_mealy

Parametrised Mealy sequence detector. It scans a serial bit stream for a run-time programmable pattern of `LEN` bits. The match output is Mealy: it asserts combinationally in the same cycle as the completing bit. The block adds start/stop control, overlapping or non-overlapping detection, a saturating match counter, and an optional match limit that stops the detector. It sits on serial input paths as a generalised, configurable replacement for fixed-pattern hand-coded Mealy FSMs.

## Interface
- `LEN`, default 4: pattern length in bits; legal range 2..32.
- `CNT_W`, default 8: width of the match counter and of the match limit.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: arm detector; samples the cfg_* inputs.
- `stop` in 1: abort and return to IDLE.
- `cfg_pattern` in LEN: target pattern; bit LEN-1 is the oldest (first-received) bit, bit 0 the newest.
- `cfg_overlap` in 1: 1 = overlapping detection, 0 = non-overlapping.
- `cfg_limit` in CNT_W: number of matches after which the block enters DONE; 0 = unlimited.
- `in_valid` in 1: `in` carries a stream bit this cycle.
- `in` in 1: serial data bit.
- `match` out 1: Mealy match indication, combinational.
- `match_count` out CNT_W: matches since the last start, saturating.
- `busy` out 1: state == RUN.
- `done` out 1: state == DONE.

## Operation
- State machine: IDLE, RUN, DONE. Encoding is free.
- Reset: state IDLE; hist, fill and match_count are 0; the latched config is 0; all outputs are 0.
- IDLE:
  - `match` = 0.
  - `match_count` holds its last value.
  - `start` = 1: latch cfg_pattern, cfg_overlap and cfg_limit; clear hist, fill and match_count; go to RUN.
- RUN, history:
  - `hist` is a LEN-1 bit shift register holding the most recent bits.
  - `fill` is the count of valid history bits, 0..LEN-1, width `$clog2(LEN)`.
- RUN, match condition:
  - `match` = in_valid && !stop && (fill == LEN-1) && ({hist, in} == pattern).
- RUN, on in_valid without a match:
  - hist <= {hist[LEN-3:0], in} (for LEN=2, hist <= in).
  - fill <= min(fill+1, LEN-1).
- RUN, on a match:
  - match_count <= match_count+1, saturating at 2^CNT_W-1.
  - Overlap mode: hist and fill update as for a non-match, so the trailing bits count towards the next match.
  - Non-overlap mode: fill <= 0. The next match needs LEN fresh bits.
  - If limit != 0 and the incremented count equals limit: go to DONE.
- RUN, cycles with in_valid = 0: hist, fill and match_count hold; match = 0.
- RUN, `start` is ignored.
- RUN, `stop` takes priority over everything:
  - go to IDLE, suppress match that cycle, leave match_count unchanged.
- DONE:
  - `match` = 0; in_valid is ignored.
  - match_count holds.
  - `start` re-arms exactly as from IDLE.
  - `stop` goes to IDLE.
  - If start and stop are both asserted, stop wins.
- IDLE with start and stop both asserted: start wins. stop has no meaning in IDLE.
- Saturation: when match_count reaches all-ones it stays there. A limit that equals all-ones still triggers DONE.
- `rst` overrides everything, including mid-pattern and in DONE. The partial history is discarded.

## Timing
- Arming latency: start is sampled at edge N and the state is RUN from cycle N+1. A bit presented in cycle N is not scanned.
- Match latency is zero: `match` is high in the same cycle as the completing in_valid bit.
- `match_count` reflects that match one cycle later.
- DONE entry: `done` and `busy`=0 are visible the cycle after the limit-reaching match.
- Combinational path: `in`/`in_valid`/`stop` → `match` is the only one. `busy`, `done` and `match_count` are registered-state decodes.
- Minimum spacing between matches:
  - overlap mode: 1 valid bit, e.g. pattern 1111 on an all-ones stream;
  - non-overlap mode: LEN valid bits.

## Test plan
- Reset, then LEN=4, pattern 1011, overlap=1, limit 0; stream 1,0,1,1,0,1,1 → match high on bits 4 and 7; match_count = 2.
- Same stream with overlap=0 → match high only on bit 4; match_count = 1.
- Pattern 1111, overlap=1, limit 3; seven 1s → match on bits 4, 5, 6; done high the cycle after bit 6; bit 7 gives no match; match_count = 3.
- in_valid gaps: pattern 1011 with in_valid=0 cycles between bits, and `in` toggling during those gaps → same matches as the gap-free stream; match never high while in_valid=0.
- stop asserted in the same cycle as a completing bit → match = 0, count unchanged, IDLE next cycle. Then start with a new pattern 0110 → detection restarts from an empty history (first possible match on the 4th bit).
- CNT_W=2, limit 0, pattern 11 overlap; six 1s → match_count 1, 2, 3, 3, 3; rst mid-stream → all outputs 0 on the next cycle.
